// File: rtl/bit_window_sampler.sv
// Captures a 6-bit MSB-first serial frame, one bit every tick_div+1 cycles, and holds it until the consumer accepts it.
// Optional MAJORITY_VOTE_EN: each bit is a 2-of-3 vote over the last three counter positions of its period.
module bit_window_sampler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       start,
  input  logic [7:0] tick_div,
  output logic [5:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tdiv_q, tdiv_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [5:0]  shift_q, shift_d;
  logic [5:0]  frame_q, frame_d;
  logic        frame_valid_q, frame_valid_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  tdiv_latch;
  logic        sample_bit;

`ifdef MAJORITY_VOTE_EN
  logic [1:0]  vote_q, vote_d;

  // Clamping the period to at least 3 cycles guarantees three distinct vote positions.
  assign tdiv_latch = (tick_div < 8'd2) ? 8'd2 : tick_div;
  assign sample_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & din) | (vote_q[1] & din);

  always_comb begin
    vote_d = vote_q;
    if (state_q == FILL) begin
      if (cnt_q == tdiv_q - 8'd2) vote_d[0] = din;
      if (cnt_q == tdiv_q - 8'd1) vote_d[1] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vote_q <= 2'b00;
    else        vote_q <= vote_d;
  end
`else
  assign tdiv_latch = tick_div;
  assign sample_bit = din;
`endif

  always_comb begin
    state_d       = state_q;
    tdiv_d        = tdiv_q;
    cnt_d         = cnt_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FILL;
          tdiv_d   = tdiv_latch;
          cnt_d    = 8'd0;
          bitcnt_d = 3'd0;
        end
      end
      FILL: begin
        if (cnt_q == tdiv_q) begin
          cnt_d   = 8'd0;
          shift_d = {shift_q[4:0], sample_bit};
          if (bitcnt_q == 3'd5) begin
            state_d       = HOLD;
            frame_d       = {shift_q[4:0], sample_bit};
            frame_valid_d = 1'b1;
            bitcnt_d      = 3'd0;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          if (start) begin
            // Back-to-back: the accepted frame frees the slot, so a start here is not lost.
            state_d  = FILL;
            tdiv_d   = tdiv_latch;
            cnt_d    = 8'd0;
            bitcnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tdiv_q        <= 8'd0;
      cnt_q         <= 8'd0;
      bitcnt_q      <= 3'd0;
      shift_q       <= 6'd0;
      frame_q       <= 6'd0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tdiv_q        <= tdiv_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_bit_window_sampler.sv
// Directed bench for bit_window_sampler in its default build (no majority voting).
module tb_bit_window_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       start;
  logic [7:0] tick_div;
  logic [5:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  bit_window_sampler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .start       (start),
    .tick_div    (tick_div),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a capture and feeds din per cycle; glitch<0 sends bits MSB-first,
  // otherwise din is 1 except 0 when the cycle's counter position equals glitch.
  task automatic run_frame(input string tag, input logic [7:0] td, input logic [5:0] bits,
                           input int glitch, input logic [5:0] exp);
    int p;
    int idx;
    logic [5:0] b;
    p = int'(td) + 1;
    b = bits;
    start = 1'b1;
    tick_div = td;
    step();
    start = 1'b0;
    for (int c = 0; c < 6 * p; c++) begin
      idx = 5 - c / p;
      din = (glitch < 0) ? b[idx] : ((c % p) == glitch ? 1'b0 : 1'b1);
      tick_div = 8'($urandom_range(0, 255));
      if (c == 6 * p - 1) chk({tag, "_fv_early"}, frame_valid, 1'b0);
      step();
    end
    chk({tag, "_fv"}, frame_valid, 1'b1);
    chk({tag, "_frame"}, frame, exp);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic drain(input string tag);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk({tag, "_drain_fv"}, frame_valid, 1'b0);
    chk({tag, "_drain_busy"}, busy, 1'b0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    din = 1'b0;
    start = 1'b1;
    tick_div = 8'd0;
    frame_ready = 1'b0;
    step();
    step();
    chk("rst_frame", frame, 6'd0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    chk("start_in_rst_ignored", busy, 1'b0);

    run_frame("td0", 8'd0, 6'b101001, -1, 6'b101001);

    // Held frame must not move while the consumer stalls, whatever din does.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      din = 1'($urandom_range(0, 1));
      step();
      if (frame !== 6'b101001 || frame_valid !== 1'b1) bad++;
    end
    chk("hold_stable", bad, 0);
    drain("td0");

    run_frame("td1", 8'd1, 6'b110010, -1, 6'b110010);
    chk("td1_ovr0", overrun, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_frame", frame, 6'b110010);
    chk("ovr_fv", frame_valid, 1'b1);
    step();

    // Transfer and start in the same cycle: straight back to FILL without flagging.
    frame_ready = 1'b1;
    run_frame("b2b", 8'd0, 6'b011100, -1, 6'b011100);
    frame_ready = 1'b0;
    chk("b2b_ovr_kept", overrun, 1'b1);
    drain("b2b");

    // Reset lands on the third sample edge (E0 + 12 with P = 4).
    start = 1'b1;
    tick_div = 8'd3;
    din = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_frame", frame, 6'd0);
    chk("abort_fv", frame_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ovr", overrun, 1'b0);
    step();
    chk("abort_fv_after", frame_valid, 1'b0);
    run_frame("td3", 8'd3, 6'b100111, -1, 6'b100111);
    drain("td3");

    run_frame("glitch_at_T", 8'd4, 6'd0, 4, 6'b000000);
    drain("glitch_at_T");
    run_frame("glitch_at_3", 8'd4, 6'd0, 3, 6'b111111);
    drain("glitch_at_3");

    run_frame("td255", 8'd255, 6'b010110, -1, 6'b010110);
    drain("td255");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_window_sampler.md
BIT_WINDOW_SAMPLER -- requirements
Module: bit_window_sampler

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 din  in  1  serial data bit to be sampled.
REQ-004 start  in  1  single-cycle request to begin capturing one 6-bit frame.
REQ-005 tick_div  in  8  sample period minus one, in clk cycles; latched when a capture starts.
REQ-006 frame  out  6  captured window; feeds the downstream gap-fill stage's 6-bit input directly.
REQ-007 frame_valid  out  1  frame holds a complete, stable capture.
REQ-008 frame_ready  in  1  downstream accepts frame; transfer occurs when frame_valid && frame_ready.
REQ-009 busy  out  1  high in FILL and HOLD.
REQ-010 overrun  out  1  sticky flag: start was lost while a frame was pending.

Function
REQ-011 The FSM SHALL have three states: IDLE, FILL, HOLD.
REQ-012 In IDLE, start=1 SHALL latch tick_div, clear the tick counter and bit count, and enter FILL on the next edge.
REQ-013 In FILL, the tick counter SHALL count 0..latched tick_div and wrap to 0; on the wrap edge one bit SHALL be sampled.
REQ-014 Sampling SHALL shift MSB-first: shift <= {shift[4:0], bit}; the first sampled bit ends in frame[5], the sixth in frame[0].
REQ-015 With start seen at edge E0 and P = tick_div+1, samples SHALL occur at edges E0+k*P, k=1..6; FSM SHALL enter HOLD and assert frame_valid at edge E0+6*P.
REQ-016 frame SHALL update only on entry to HOLD and SHALL stay constant while frame_valid=1.
REQ-017 In HOLD, a transfer SHALL deassert frame_valid and return to IDLE on the same edge, unless start=1 in that cycle, in which case FSM SHALL go directly to FILL (REQ-012 actions) with no overrun.
REQ-018 start in FILL SHALL be ignored with no flag.
REQ-019 start in HOLD without a transfer in the same cycle SHALL be dropped and SHALL set overrun=1.
REQ-020 overrun SHALL clear only on reset.
REQ-021 tick_div changes after latching SHALL have no effect on the frame in progress.
REQ-022 tick_div=0 SHALL be legal: one sample per cycle, frame_valid six edges after start.
REQ-023 tick_div=255 SHALL give P=256 with no counter overflow.

Reset
REQ-024 When rst_n=0 at a rising edge, the block SHALL enter IDLE and set frame=6'b000000, frame_valid=0, busy=0, overrun=0, and clear the tick counter, bit count, and shift register.
REQ-025 A reset during FILL or HOLD SHALL abort the capture; no partial frame is ever presented.
REQ-026 start during a reset cycle SHALL be ignored.

Configuration
REQ-027 Macro MAJORITY_VOTE_EN: when defined, each bit SHALL be the 2-of-3 majority of din sampled at tick counter values T-2, T-1, and T, where T = max(latched tick_div, 2).
REQ-028 With MAJORITY_VOTE_EN defined, the period SHALL be P = T+1 and REQ-015 timing SHALL use this P.
REQ-029 Without MAJORITY_VOTE_EN, each bit SHALL be the single din value at counter = tick_div, and no voting logic SHALL be present.

Verification
REQ-030 tick_div=0, start, din=1,0,1,0,0,1 on successive cycles -> frame_valid after 6 edges, frame=6'b101001.
REQ-031 After REQ-030, frame_ready=0 for 10 cycles -> frame and frame_valid stable; then ready=1 for one cycle -> IDLE, busy=0.
REQ-032 In HOLD with frame_ready=0, pulse start -> overrun=1 and frame unchanged; pulse start with frame_ready=1 -> new FILL, overrun unchanged.
REQ-033 tick_div=3, start, then rst_n=0 on 3rd sample edge -> all outputs zero next cycle, IDLE; a new start then captures correctly.
REQ-034 MAJORITY_VOTE_EN defined, tick_div=4, din held 1 except a one-cycle 0 at counter=3 of each bit -> frame=6'b111111 after 30 edges; without the macro, a glitch at counter=4 gives 0 bits.
